fetch_controller: RTL and testbench

Instruction-fetch sequencer for the 8085 core. It drives the program counter's control inputs (`en`, `en_read`, `inc`, `ld_high`) and the memory read strobes to fetch a 1–3 byte instruction into the instruction and operand registers. For taken jumps it reloads the PC from the fetched operand bytes over the 8-bit data bus. It sits between the instruction decoder and the program counter/memory interface.

---
 rtl/fetch_controller_if.sv | 34 +++
 rtl/fetch_controller.sv | 137 +++++++++++++
 tb/tb_fetch_controller.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Fetch-sequencer signal bundle: decoder/memory inputs and PC/strobe/register controls.
interface fetch_controller_if;
  logic       start;
  logic       ready;
  logic [1:0] num_bytes;
  logic       is_jump;
  logic       cond_ok;

  logic       pc_en;
  logic       pc_en_read;
  logic       pc_inc;
  logic       pc_ld_high;
  logic       ale;
  logic       rd;
  logic       ir_load;
  logic       opr_lo_load;
  logic       opr_hi_load;
  logic       opr_lo_drive;
  logic       opr_hi_drive;
  logic       busy;
  logic       done;

  modport master (
    input  start, ready, num_bytes, is_jump, cond_ok,
    output pc_en, pc_en_read, pc_inc, pc_ld_high, ale, rd, ir_load, opr_lo_load, opr_hi_load,
           opr_lo_drive, opr_hi_drive, busy, done
  );

  modport slave (
    output start, ready, num_bytes, is_jump, cond_ok,
    input  pc_en, pc_en_read, pc_inc, pc_ld_high, ale, rd, ir_load, opr_lo_load, opr_hi_load,
           opr_lo_drive, opr_hi_drive, busy, done
  );
endinterface

// File: rtl/fetch_controller.sv
// Moore FSM that fetches a 1-3 byte 8085 instruction and, for taken jumps,
// reloads the PC from the operand registers over the data bus.
module fetch_controller (
  input  logic                clk,
  input  logic                reset,
  fetch_controller_if.master  bus
);

  typedef enum logic [3:0] {
    StIdle,
    StOpAddr,
    StOpRead,
    StOpLatch,
    StDecode,
    StB2Addr,
    StB2Read,
    StB2Latch,
    StB3Addr,
    StB3Read,
    StB3Latch,
    StJmpLo,
    StJmpHi,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] len_q, len_d;
  logic       take_q, take_d;
  logic [1:0] len_dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= 2'd0;
      take_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      take_q  <= take_d;
    end
  end

  // A zero length from the decoder is treated as a single-byte opcode.
  assign len_dec = (bus.num_bytes == 2'd0) ? 2'd1 : bus.num_bytes;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    take_d  = take_q;
    case (state_q)
      StIdle:    if (bus.start) state_d = StOpAddr;
      StOpAddr:  state_d = StOpRead;
      StOpRead:  if (bus.ready) state_d = StOpLatch;
      StOpLatch: state_d = StDecode;
      StDecode: begin
        len_d   = len_dec;
        take_d  = bus.is_jump & bus.cond_ok & (len_dec == 2'd3);
        state_d = (len_dec == 2'd1) ? StDone : StB2Addr;
      end
      StB2Addr:  state_d = StB2Read;
      StB2Read:  if (bus.ready) state_d = StB2Latch;
      StB2Latch: state_d = (len_q == 2'd2) ? StDone : StB3Addr;
      StB3Addr:  state_d = StB3Read;
      StB3Read:  if (bus.ready) state_d = StB3Latch;
      StB3Latch: state_d = take_q ? StJmpLo : StDone;
      StJmpLo:   state_d = StJmpHi;
      StJmpHi:   state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.pc_en        = 1'b0;
    bus.pc_en_read   = 1'b0;
    bus.pc_inc       = 1'b0;
    bus.pc_ld_high   = 1'b0;
    bus.ale          = 1'b0;
    bus.rd           = 1'b0;
    bus.ir_load      = 1'b0;
    bus.opr_lo_load  = 1'b0;
    bus.opr_hi_load  = 1'b0;
    bus.opr_lo_drive = 1'b0;
    bus.opr_hi_drive = 1'b0;
    bus.busy         = (state_q != StIdle);
    bus.done         = 1'b0;
    case (state_q)
      StOpAddr, StB2Addr, StB3Addr: begin
        bus.pc_en = 1'b1;
        bus.ale   = 1'b1;
      end
      StOpRead, StB2Read, StB3Read: begin
        bus.pc_en = 1'b1;
        bus.rd    = 1'b1;
      end
      StOpLatch: begin
        bus.pc_en   = 1'b1;
        bus.rd      = 1'b1;
        bus.pc_inc  = 1'b1;
        bus.ir_load = 1'b1;
      end
      StB2Latch: begin
        bus.pc_en       = 1'b1;
        bus.rd          = 1'b1;
        bus.pc_inc      = 1'b1;
        bus.opr_lo_load = 1'b1;
      end
      StB3Latch: begin
        bus.pc_en       = 1'b1;
        bus.rd          = 1'b1;
        bus.pc_inc      = 1'b1;
        bus.opr_hi_load = 1'b1;
      end
      StJmpLo: begin
        bus.pc_en        = 1'b1;
        bus.pc_en_read   = 1'b1;
        bus.opr_lo_drive = 1'b1;
      end
      StJmpHi: begin
        bus.pc_en        = 1'b1;
        bus.pc_en_read   = 1'b1;
        bus.pc_ld_high   = 1'b1;
        bus.opr_hi_drive = 1'b1;
      end
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // The PC must never be loaded and incremented at once, and Z/W must never fight memory.
  a_no_inc_and_load : assert property (@(posedge clk) disable iff (reset)
    !(bus.pc_en_read && bus.pc_inc));
  a_no_bus_contention : assert property (@(posedge clk) disable iff (reset)
    !((bus.opr_lo_drive && bus.opr_hi_drive) ||
      ((bus.opr_lo_drive || bus.opr_hi_drive) && bus.rd)));

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: a PC/memory environment around the DUT and a
// phase-walking timing model that predicts done/ir_load cycles and final PC.
module tb_fetch_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_controller_if bus ();

  fetch_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]  mem [0:65535];
  logic [15:0] pc;
  logic [7:0]  ir_r, z_r, w_r, data_bus;
  int          inc_count;
  bit          bad_inc_read, bad_drive;
  logic        preset;
  logic [15:0] preset_val;
  bit          ready_seq [0:255];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [12:0] outs;

  assign outs = {bus.pc_en, bus.pc_en_read, bus.pc_inc, bus.pc_ld_high, bus.ale, bus.rd,
                 bus.ir_load, bus.opr_lo_load, bus.opr_hi_load, bus.opr_lo_drive,
                 bus.opr_hi_drive, bus.busy, bus.done};

  always_comb begin
    data_bus = 8'h00;
    if (bus.rd)                data_bus = mem[pc];
    else if (bus.opr_lo_drive) data_bus = z_r;
    else if (bus.opr_hi_drive) data_bus = w_r;
  end

  // Program counter plus IR/Z/W registers as seen by the controller.
  always @(posedge clk) begin
    if (preset) begin
      pc           <= preset_val;
      inc_count    <= 0;
      bad_inc_read <= 1'b0;
      bad_drive    <= 1'b0;
      ir_r         <= 8'h00;
      z_r          <= 8'h00;
      w_r          <= 8'h00;
    end else begin
      if (bus.pc_en && bus.pc_inc) begin
        pc        <= pc + 16'd1;
        inc_count <= inc_count + 1;
      end
      if (bus.pc_en && bus.pc_en_read) begin
        if (bus.pc_ld_high) pc[15:8] <= data_bus;
        else                pc[7:0]  <= data_bus;
      end
      if (bus.ir_load)     ir_r <= data_bus;
      if (bus.opr_lo_load) z_r  <= data_bus;
      if (bus.opr_hi_load) w_r  <= data_bus;
      if (bus.pc_en_read && bus.pc_inc) bad_inc_read <= 1'b1;
      if ((bus.opr_lo_drive && bus.opr_hi_drive) ||
          ((bus.opr_lo_drive || bus.opr_hi_drive) && bus.rd)) bad_drive <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walks the fetch phases: addr, read (+waits), latch, decode after the opcode, jump reload.
  task automatic model_fetch(input int len, input bit take, output int ir_cyc,
                             output int done_cyc, output int rd_cyc);
    int c;
    c      = 0;
    ir_cyc = 0;
    rd_cyc = 0;
    for (int b = 0; b < len; b++) begin
      c++;
      c++;
      rd_cyc++;
      while (c < 255 && !ready_seq[c]) begin
        c++;
        rd_cyc++;
      end
      c++;
      rd_cyc++;
      if (b == 0) begin
        ir_cyc = c;
        c++;
      end
    end
    if (take) c += 2;
    done_cyc = c + 1;
  endtask

  task automatic fill_ready(input int pct_wait);
    for (int i = 0; i < 256; i++)
      ready_seq[i] = (i < 40 && $urandom_range(99) < pct_wait) ? 1'b0 : 1'b1;
  endtask

  task automatic run_fetch(input string tag, input logic [15:0] spc, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2, input int nb,
                           input bit jmp, input bit cok, input int rst_cyc);
    int          len, exp_ir, exp_done, exp_rd;
    int          got_ir, got_done, n_done, n_rd;
    bit          take;
    logic [15:0] exp_pc;
    len      = (nb == 0) ? 1 : nb;
    take     = jmp && cok && (len == 3);
    got_ir   = -1;
    got_done = -1;
    n_done   = 0;
    n_rd     = 0;
    mem[spc]         = b0;
    mem[spc + 16'd1] = b1;
    mem[spc + 16'd2] = b2;
    model_fetch(len, take, exp_ir, exp_done, exp_rd);
    exp_pc = take ? {b2, b1} : spc + 16'(len);

    @(negedge clk);
    preset_val    = spc;
    preset        = 1'b1;
    bus.start     = 1'b0;
    bus.ready     = 1'b1;
    bus.num_bytes = nb[1:0];
    bus.is_jump   = jmp;
    bus.cond_ok   = cok;
    @(negedge clk);
    preset = 1'b0;
    check_eq({tag, "_idle_before"}, 32'(outs), 32'd0);

    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.start = (cyc == 0);
      bus.ready = ready_seq[cyc];
      reset     = (cyc == rst_cyc);
      if (bus.ir_load && got_ir < 0) got_ir = cyc;
      if (bus.rd) n_rd++;
      if (bus.done) begin
        n_done++;
        if (got_done < 0) got_done = cyc;
      end
      if (rst_cyc < 0 && got_done >= 0 && cyc == got_done + 1) begin
        check_eq({tag, "_idle_after"}, 32'(outs), 32'd0);
        break;
      end
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        check_eq({tag, "_busy_after_reset"}, 32'(bus.busy), 32'd0);
        break;
      end
    end
    bus.start = 1'b0;
    reset     = 1'b0;

    if (rst_cyc < 0) begin
      check_eq({tag, "_done_cycle"}, 32'(got_done), 32'(exp_done));
      check_eq({tag, "_ir_cycle"}, 32'(got_ir), 32'(exp_ir));
      check_eq({tag, "_done_pulses"}, 32'(n_done), 32'd1);
      check_eq({tag, "_rd_cycles"}, 32'(n_rd), 32'(exp_rd));
      check_eq({tag, "_pc"}, 32'(pc), 32'(exp_pc));
      check_eq({tag, "_ir"}, 32'(ir_r), 32'(b0));
      check_eq({tag, "_z"}, 32'(z_r), (len >= 2) ? 32'(b1) : 32'd0);
      check_eq({tag, "_w"}, 32'(w_r), (len == 3) ? 32'(b2) : 32'd0);
      check_eq({tag, "_incs"}, 32'(inc_count), 32'(len));
    end else begin
      check_eq({tag, "_no_done"}, 32'(n_done), 32'd0);
      check_eq({tag, "_pc_hi_kept"}, 32'(pc[15:8]), 32'(spc[15:8]));
      @(negedge clk);
      check_eq({tag, "_idle_after_reset"}, 32'(outs), 32'd0);
    end
    check_eq({tag, "_inc_read_overlap"}, 32'(bad_inc_read), 32'd0);
    check_eq({tag, "_bus_contention"}, 32'(bad_drive), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    preset        = 1'b1;
    preset_val    = 16'h0000;
    bus.start     = 1'b0;
    bus.ready     = 1'b1;
    bus.num_bytes = 2'd1;
    bus.is_jump   = 1'b0;
    bus.cond_ok   = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hFF;
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", 32'(outs), 32'd0);
    reset  = 1'b0;
    preset = 1'b0;

    fill_ready(0);
    run_fetch("one_byte", 16'h0000, 8'h00, 8'h11, 8'h22, 1, 1'b0, 1'b0, -1);
    run_fetch("three_nojmp", 16'h0010, 8'h21, 8'hA5, 8'h5A, 3, 1'b0, 1'b0, -1);
    run_fetch("jmp_taken", 16'h0020, 8'hC3, 8'h34, 8'h12, 3, 1'b1, 1'b1, -1);
    run_fetch("jmp_not_taken", 16'h0020, 8'hC3, 8'h34, 8'h12, 3, 1'b1, 1'b0, -1);
    run_fetch("jmp_len2", 16'h0020, 8'hC3, 8'h34, 8'h12, 2, 1'b1, 1'b1, -1);
    run_fetch("len_zero", 16'h0030, 8'h76, 8'h99, 8'h88, 0, 1'b0, 1'b0, -1);

    fill_ready(0);
    ready_seq[6] = 1'b0;
    ready_seq[7] = 1'b0;
    ready_seq[8] = 1'b0;
    run_fetch("b2_wait", 16'h0050, 8'h3E, 8'h42, 8'h00, 2, 1'b0, 1'b0, -1);

    // Cycle 11 is JMP_LO for a taken 3-byte jump with no waits.
    fill_ready(0);
    run_fetch("reset_jmp_lo", 16'h5540, 8'hC3, 8'h34, 8'h12, 3, 1'b1, 1'b1, 11);
    run_fetch("after_reset", 16'h0060, 8'hC3, 8'hCD, 8'hAB, 3, 1'b1, 1'b1, -1);

    for (int k = 0; k < 40; k++) begin
      fill_ready(25);
      run_fetch("random", 16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
